// File: rtl/wb32_dma_copy_pkg.sv
// Shared types for the Wishbone block copy/fill engine.
// State encoding, byte-select constant and start dispatch helper.
package wb32_dma_copy_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR     = 3'd3,
        S_WR_GAP = 3'd4,
        S_DONE   = 3'd5
    } dma_state_t;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    // First state after an accepted start.
    function automatic dma_state_t start_target(
        input logic len_zero,
        input logic fill
    );
        if (len_zero)
            return S_DONE;
        else if (fill)
            return S_WR;
        else
            return S_RD;
    endfunction

endpackage

// File: rtl/wb32_dma_copy.sv
// Wishbone 32-bit initiator copying or filling a block of RAM words.
// One strobed access at a time; stb drops for a cycle after every ack.
module wb32_dma_copy
    import wb32_dma_copy_pkg::*;
#(
    parameter int ADDRBITS = 11,
    parameter int LENBITS  = 11
) (
    input  logic                I_wb_clk,
    input  logic                I_wb_reset_n,
    input  logic                I_start,
    input  logic                I_abort,
    input  logic                I_fill_en,
    input  logic [ADDRBITS-1:0] I_src_adr,
    input  logic [ADDRBITS-1:0] I_dst_adr,
    input  logic [LENBITS:0]    I_len,
    input  logic [31:0]         I_fill_dat,
    output logic                O_busy,
    output logic                O_done,
    output logic [LENBITS:0]    O_count,
    output logic                O_wb_cyc,
    output logic                O_wb_stb,
    output logic                O_wb_we,
    output logic [ADDRBITS-1:0] O_wb_adr,
    output logic [31:0]         O_wb_dat,
    output logic [3:0]          O_wb_sel,
    input  logic [31:0]         I_wb_dat,
    input  logic                I_wb_ack
);

    localparam int CW = LENBITS + 1;

    dma_state_t          state;
    dma_state_t          state_nxt;
    logic [ADDRBITS-1:0] src_q;
    logic [ADDRBITS-1:0] dst_q;
    logic [CW-1:0]       len_q;
    logic [CW-1:0]       count_q;
    logic                fill_q;
    logic [31:0]         fill_dat_q;
    logic [31:0]         data_q;
    logic                abort_q;
    logic                abort_pend;
    logic                last_word;

    assign abort_pend = abort_q | I_abort;
    assign last_word  = (count_q == len_q);
    assign O_count    = count_q;

    // State register; reset drops the bus at once, without waiting for ack.
    always_ff @(posedge I_wb_clk) begin
        if (!I_wb_reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and bus/status outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        O_busy    = 1'b1;
        O_done    = 1'b0;
        O_wb_cyc  = 1'b0;
        O_wb_stb  = 1'b0;
        O_wb_we   = 1'b0;
        O_wb_adr  = '0;
        O_wb_dat  = '0;
        O_wb_sel  = '0;
        unique case (state)
            S_IDLE: begin
                O_busy = 1'b0;
                if (I_start)
                    state_nxt = start_target(I_len == '0, I_fill_en);
            end
            S_RD: begin
                O_wb_cyc = 1'b1;
                O_wb_stb = 1'b1;
                O_wb_adr = src_q;
                O_wb_sel = SEL_ALL;
                if (I_wb_ack)
                    state_nxt = S_RD_GAP;
            end
            S_RD_GAP: begin
                O_wb_cyc  = 1'b1;
                state_nxt = S_WR;
            end
            S_WR: begin
                O_wb_cyc = 1'b1;
                O_wb_stb = 1'b1;
                O_wb_we  = 1'b1;
                O_wb_adr = dst_q;
                O_wb_dat = fill_q ? fill_dat_q : data_q;
                O_wb_sel = SEL_ALL;
                if (I_wb_ack)
                    state_nxt = S_WR_GAP;
            end
            S_WR_GAP: begin
                O_wb_cyc = 1'b1;
                if (last_word || abort_pend)
                    state_nxt = S_DONE;
                else if (fill_q)
                    state_nxt = S_WR;
                else
                    state_nxt = S_RD;
            end
            S_DONE: begin
                O_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                O_busy    = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer parameters, address/count stepping and the sticky abort.
    always_ff @(posedge I_wb_clk) begin
        if (!I_wb_reset_n) begin
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            count_q    <= '0;
            fill_q     <= 1'b0;
            fill_dat_q <= '0;
            data_q     <= '0;
            abort_q    <= 1'b0;
        end else begin
            if (state == S_IDLE)
                abort_q <= 1'b0;
            else
                abort_q <= abort_q | I_abort;

            if (state == S_IDLE && I_start) begin
                src_q      <= I_src_adr;
                dst_q      <= I_dst_adr;
                len_q      <= I_len;
                fill_q     <= I_fill_en;
                fill_dat_q <= I_fill_dat;
                count_q    <= '0;
            end

            if (state == S_RD && I_wb_ack) begin
                data_q <= I_wb_dat;
                src_q  <= src_q + ADDRBITS'(1);
            end

            if (state == S_WR && I_wb_ack) begin
                dst_q   <= dst_q + ADDRBITS'(1);
                count_q <= count_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb32_dma_copy.sv
// Randomised and directed bench for wb32_dma_copy.
// Includes a registered-ack RAM responder and a word-level reference model.
module tb_wb32_dma_copy;

    localparam int AB = 11;
    localparam int LB = 11;
    localparam int NW = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          fill_en;
    logic [AB-1:0] src_adr;
    logic [AB-1:0] dst_adr;
    logic [LB:0]   len;
    logic [31:0]   fill_dat;
    logic          busy;
    logic          done;
    logic [LB:0]   count;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AB-1:0] adr;
    logic [31:0]   wdat;
    logic [3:0]    sel;
    logic [31:0]   rdat;
    logic          ack;

    logic          bd_we;
    logic [AB-1:0] bd_adr;
    logic [31:0]   bd_dat;

    logic [31:0] mem     [0:NW-1];
    logic [31:0] ref_mem [0:NW-1];

    logic [AB-1:0] exp_rd_adr[$];
    logic [AB-1:0] exp_wr_adr[$];
    logic [31:0]   exp_wr_dat[$];

    int tests = 0;
    int fails = 0;
    int n_acks = 0;
    int n_strobes = 0;
    logic prev_ack = 1'b0;
    logic prev_stb = 1'b0;

    always #5 clk = ~clk;

    wb32_dma_copy #(.ADDRBITS(AB), .LENBITS(LB)) dut (
        .I_wb_clk    (clk),
        .I_wb_reset_n(rst_n),
        .I_start     (start),
        .I_abort     (abort),
        .I_fill_en   (fill_en),
        .I_src_adr   (src_adr),
        .I_dst_adr   (dst_adr),
        .I_len       (len),
        .I_fill_dat  (fill_dat),
        .O_busy      (busy),
        .O_done      (done),
        .O_count     (count),
        .O_wb_cyc    (cyc),
        .O_wb_stb    (stb),
        .O_wb_we     (we),
        .O_wb_adr    (adr),
        .O_wb_dat    (wdat),
        .O_wb_sel    (sel),
        .I_wb_dat    (rdat),
        .I_wb_ack    (ack)
    );

    // bram_wb32-style responder: registered ack one cycle after stb.
    always @(posedge clk) begin
        if (bd_we)
            mem[bd_adr] <= bd_dat;
        if (!rst_n) begin
            ack <= 1'b0;
        end else begin
            ack <= cyc && stb && !ack;
            if (cyc && stb && !ack) begin
                if (we)
                    mem[adr] <= wdat;
                rdat <= mem[adr];
            end
        end
    end

    // Bus checker against the model's expected access sequence.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stb) begin
                tests++;
                if (sel !== 4'hF) begin
                    fails++;
                    $display("FAIL sel: got %h want f", sel);
                end
                if (!prev_stb)
                    n_strobes++;
            end
            if (prev_ack) begin
                tests++;
                if (stb !== 1'b0) begin
                    fails++;
                    $display("FAIL stb_gap: stb=%b right after ack, want 0", stb);
                end
            end
            if (stb && ack) begin
                n_acks++;
                tests++;
                if (we) begin
                    if (exp_wr_adr.size() == 0) begin
                        fails++;
                        $display("FAIL wr_extra: adr=%h dat=%h, none expected",
                                 adr, wdat);
                    end else begin
                        logic [AB-1:0] ea;
                        logic [31:0]   ed;
                        ea = exp_wr_adr.pop_front();
                        ed = exp_wr_dat.pop_front();
                        if (adr !== ea || wdat !== ed) begin
                            fails++;
                            $display("FAIL wr_access: got %h/%h want %h/%h",
                                     adr, wdat, ea, ed);
                        end
                    end
                end else begin
                    if (exp_rd_adr.size() == 0) begin
                        fails++;
                        $display("FAIL rd_extra: adr=%h, none expected", adr);
                    end else begin
                        logic [AB-1:0] ra;
                        ra = exp_rd_adr.pop_front();
                        if (adr !== ra) begin
                            fails++;
                            $display("FAIL rd_access: got %h want %h", adr, ra);
                        end
                    end
                end
            end
        end
        prev_ack = ack;
        prev_stb = stb;
    end

    task automatic check(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic poke(input logic [AB-1:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we  = 1'b1;
        bd_adr = a;
        bd_dat = d;
        ref_mem[a] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < NW; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d words differ, first at %h got %h want %h",
                     name, bad, first, mem[first], ref_mem[first]);
        end
    endtask

    // Word-level model: k ascending read/write pairs (or fill writes).
    task automatic model(input logic [AB-1:0] s, input logic [AB-1:0] d,
                         input int k, input logic f, input logic [31:0] fd);
        for (int i = 0; i < k; i++) begin
            logic [AB-1:0] as;
            logic [AB-1:0] ad;
            as = s + AB'(i);
            ad = d + AB'(i);
            if (f) begin
                ref_mem[ad] = fd;
            end else begin
                exp_rd_adr.push_back(as);
                ref_mem[ad] = ref_mem[as];
            end
            exp_wr_adr.push_back(ad);
            exp_wr_dat.push_back(ref_mem[ad]);
        end
    endtask

    task automatic run_xfer(input string name,
                            input logic [AB-1:0] s, input logic [AB-1:0] d,
                            input int l, input logic f, input logic [31:0] fd,
                            input int ab);
        int k;
        int acks0;
        int stbs0;
        int busy_t = -1;
        int done_t = -1;
        int done_n = 0;
        int rd_idx = 0;
        int tail = 0;
        logic p_stb = 1'b0;
        bit finished = 0;
        k = (ab != 0 && !f && ab <= l) ? ab : l;
        model(s, d, k, f, fd);
        acks0 = n_acks;
        stbs0 = n_strobes;
        @(negedge clk);
        start    = 1'b1;
        src_adr  = s;
        dst_adr  = d;
        len      = (LB+1)'(l);
        fill_en  = f;
        fill_dat = fd;
        for (int t = 1; t < 5000 && !finished; t++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (busy && busy_t < 0) busy_t = t;
            if (done) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            if (stb && !we && !p_stb) begin
                rd_idx++;
                if (ab != 0 && rd_idx == ab) abort = 1'b1;
            end
            p_stb = stb;
            if (done_t >= 0) begin
                tail++;
                if (tail > 3) finished = 1;
            end
        end
        abort = 1'b0;
        tests++;
        if (!finished) begin
            fails++;
            $display("FAIL %s_timeout: no done within bound", name);
        end
        check({name, "_done_pulses"}, done_n, 1);
        check({name, "_latency"}, done_t - busy_t, (f ? 3 : 6) * k);
        check({name, "_count"}, count, k);
        check({name, "_ack_vs_stb"}, n_acks - acks0, n_strobes - stbs0);
        check({name, "_left_wr"}, exp_wr_adr.size(), 0);
        check({name, "_left_rd"}, exp_rd_adr.size(), 0);
        check_mem({name, "_mem"});
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        fill_en  = 1'b0;
        src_adr  = '0;
        dst_adr  = '0;
        len      = '0;
        fill_dat = '0;
        bd_we    = 1'b0;
        bd_adr   = '0;
        bd_dat   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, done, count, cyc, stb, we, adr, wdat, sel}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            bd_we  = 1'b1;
            bd_adr = AB'(i);
            bd_dat = $urandom;
            ref_mem[i] = bd_dat;
        end
        @(negedge clk);
        bd_we = 1'b0;

        for (int i = 0; i < 4; i++)
            poke(AB'(11'h10 + i), 32'hA0A0_0000 | i);
        run_xfer("copy4", 11'h010, 11'h040, 4, 1'b0, 32'h0, 0);
        check("copy4_lit0", mem[11'h40], 32'hA0A0_0000);
        check("copy4_lit3", mem[11'h43], 32'hA0A0_0003);

        run_xfer("fill_wrap", 11'h000, 11'h7FE, 4, 1'b1, 32'hDEADBEEF, 0);
        check("fill_lit7fe", mem[11'h7FE], 32'hDEADBEEF);
        check("fill_lit001", mem[11'h001], 32'hDEADBEEF);

        run_xfer("len0", 11'h123, 11'h321, 0, 1'b0, 32'h0, 0);

        run_xfer("abort2", 11'h200, 11'h300, 8, 1'b0, 32'h0, 2);
        check("abort2_lit_count", count, 2);

        for (int r = 0; r < 24; r++) begin
            logic [AB-1:0] s;
            logic [AB-1:0] d;
            int l;
            logic f;
            int ab;
            s  = AB'($urandom);
            d  = AB'($urandom);
            if (r % 6 == 1) d = s + AB'(1);
            if (r % 6 == 2) d = s - AB'(1);
            l  = $urandom_range(0, 10);
            f  = 1'($urandom_range(0, 1));
            ab = (r % 4 == 3) ? $urandom_range(1, 4) : 0;
            run_xfer($sformatf("rand%0d", r), s, d, l, f, $urandom, ab);
        end

        begin
            int wr_n = 0;
            logic p_stb = 1'b0;
            bit hit = 0;
            model(11'h500, 11'h600, 1, 1'b0, 32'h0);
            exp_rd_adr.push_back(11'h501);
            @(negedge clk);
            start   = 1'b1;
            src_adr = 11'h500;
            dst_adr = 11'h600;
            len     = 12'd4;
            fill_en = 1'b0;
            for (int t = 0; t < 200 && !hit; t++) begin
                @(negedge clk);
                start = 1'b0;
                if (stb && we && !p_stb) begin
                    wr_n++;
                    if (wr_n == 2) hit = 1;
                end
                p_stb = stb;
            end
            tests++;
            if (!hit) begin
                fails++;
                $display("FAIL rst_reach: second write never strobed");
            end
            check("rst_count_before", count, 1);
            rst_n = 1'b0;
            @(negedge clk);
            check("rst_cyc", cyc, 0);
            check("rst_stb", stb, 0);
            check("rst_busy", busy, 0);
            check("rst_count", count, 0);
            rst_n = 1'b1;
            check("rst_left_wr", exp_wr_adr.size(), 0);
            check("rst_left_rd", exp_rd_adr.size(), 0);
            check_mem("rst_mem");
            exp_wr_adr.delete();
            exp_wr_dat.delete();
            exp_rd_adr.delete();
        end

        run_xfer("after_rst", 11'h700, 11'h080, 5, 1'b0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
